// File: rtl/prng_sample_unpacker_if.sv
// Bundle of the start/status, PRNG-side and element-side signals of prng_sample_unpacker.
// The slave modport is the unpacker's view; the master modport is its environment's view.
interface prng_sample_unpacker_if #(
    parameter int unsigned PRNG_W = 128,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              i_start;
    logic [CNT_W-1:0]  i_no_of_elems;
    logic              o_busy;
    logic              o_done;
    logic              o_prng_start;
    logic [15:0]       o_prng_no_of_bits;
    logic              i_prng_out_valid;
    logic [PRNG_W-1:0] i_prng_out;
    logic              o_prng_out_ready;
    logic              o_elem_valid;
    logic [ELEM_W-1:0] o_elem;
    logic              i_elem_ready;

    modport slave (
        input  i_start, i_no_of_elems, i_prng_out_valid, i_prng_out, i_elem_ready,
        output o_busy, o_done, o_prng_start, o_prng_no_of_bits, o_prng_out_ready,
               o_elem_valid, o_elem
    );

    modport master (
        output i_start, i_no_of_elems, i_prng_out_valid, i_prng_out, i_elem_ready,
        input  o_busy, o_done, o_prng_start, o_prng_no_of_bits, o_prng_out_ready,
               o_elem_valid, o_elem
    );
endinterface

// File: rtl/prng_sample_unpacker.sv
// Requests PRNG words one at a time, slices each into ELEM_W-bit candidates (LSB first),
// drops candidates >= MODULUS and streams the rest out until the requested count is met.
module prng_sample_unpacker #(
    parameter int unsigned PRNG_W  = 128,
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned MODULUS = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    prng_sample_unpacker_if.slave bus
);
    localparam int unsigned SLOTS  = PRNG_W / ELEM_W;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(SLOTS - 1);
    // MODULUS covering the whole candidate range turns rejection off entirely.
    localparam bit NoReject = (64'(MODULUS) >= (64'd1 << ELEM_W));
    localparam logic [ELEM_W-1:0] ModLim = ELEM_W'(MODULUS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReq    = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StUnpack = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    function automatic logic accept(input logic [ELEM_W-1:0] c);
        return NoReject || (c < ModLim);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [PRNG_W-1:0] word_q, word_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              valid_q, valid_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              ready_q, ready_d;
    logic [15:0]       nbits_q, nbits_d;

    // Next state, counters, word shift register and the presented element.
    // o_elem_valid is registered, so the candidate of the slot being entered is judged here.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        elem_d  = elem_q;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    n_d     = bus.i_no_of_elems;
                    cnt_d   = '0;
                    state_d = (bus.i_no_of_elems != '0) ? StReq : StDone;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.i_prng_out_valid && ready_q) begin
                    word_d  = bus.i_prng_out;
                    slot_d  = '0;
                    state_d = StUnpack;
                    valid_d = accept(bus.i_prng_out[ELEM_W-1:0]);
                    if (valid_d) begin
                        elem_d = bus.i_prng_out[ELEM_W-1:0];
                    end
                end
            end
            StUnpack: begin
                // A slot is consumed when it was rejected or its element was taken.
                if (!valid_q || bus.i_elem_ready) begin
                    if (valid_q) begin
                        cnt_d = cnt_inc;
                    end
                    if (valid_q && (cnt_inc == n_q)) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                    end else if (slot_q == LastSlot) begin
                        state_d = StReq;
                        valid_d = 1'b0;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        word_d  = word_q >> ELEM_W;
                        valid_d = accept(word_d[ELEM_W-1:0]);
                        if (valid_d) begin
                            elem_d = word_d[ELEM_W-1:0];
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    // Status and PRNG-side outputs follow the state being entered so they are registered.
    always_comb begin
        busy_d  = (state_d == StReq) || (state_d == StWait) || (state_d == StUnpack);
        done_d  = (state_d == StDone);
        req_d   = (state_d == StReq);
        ready_d = (state_d == StWait);
        nbits_d = busy_d ? 16'(PRNG_W) : 16'd0;
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            elem_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            elem_q  <= elem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            nbits_q <= nbits_d;
        end
    end

    assign bus.o_busy            = busy_q;
    assign bus.o_done            = done_q;
    assign bus.o_prng_start      = req_q;
    assign bus.o_prng_no_of_bits = nbits_q;
    assign bus.o_prng_out_ready  = ready_q;
    assign bus.o_elem_valid      = valid_q;
    assign bus.o_elem            = elem_q;
endmodule

// File: tb/tb_prng_sample_unpacker.sv
// Scoreboard bench: a PRNG responder feeds words and pushes the expected accepted elements,
// a monitor pops and compares on every element handshake. Two DUTs: MODULUS 256 and 251.
module tb_prng_sample_unpacker;
    localparam int unsigned PW = 128;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    prng_sample_unpacker_if #(.PRNG_W(PW), .ELEM_W(EW), .CNT_W(CW)) bus0 ();
    prng_sample_unpacker_if #(.PRNG_W(PW), .ELEM_W(EW), .CNT_W(CW)) bus1 ();

    prng_sample_unpacker #(.PRNG_W(PW), .ELEM_W(EW), .MODULUS(256), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
    );
    prng_sample_unpacker #(.PRNG_W(PW), .ELEM_W(EW), .MODULUS(251), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );

    logic          sel = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] nreq = '0;
    logic          pvalid = 1'b0;
    logic [PW-1:0] pword = '0;
    logic          eready = 1'b0;

    assign bus0.i_start          = start & ~sel;
    assign bus1.i_start          = start & sel;
    assign bus0.i_no_of_elems    = nreq;
    assign bus1.i_no_of_elems    = nreq;
    assign bus0.i_prng_out_valid = pvalid;
    assign bus1.i_prng_out_valid = pvalid;
    assign bus0.i_prng_out       = pword;
    assign bus1.i_prng_out       = pword;
    assign bus0.i_elem_ready     = eready;
    assign bus1.i_elem_ready     = eready;

    wire          busy   = sel ? bus1.o_busy : bus0.o_busy;
    wire          done   = sel ? bus1.o_done : bus0.o_done;
    wire          preq   = sel ? bus1.o_prng_start : bus0.o_prng_start;
    wire [15:0]   nbits  = sel ? bus1.o_prng_no_of_bits : bus0.o_prng_no_of_bits;
    wire          pready = sel ? bus1.o_prng_out_ready : bus0.o_prng_out_ready;
    wire          evalid = sel ? bus1.o_elem_valid : bus0.o_elem_valid;
    wire [EW-1:0] elem   = sel ? bus1.o_elem : bus0.o_elem;

    int n_chk = 0;
    int n_pass = 0;

    logic [EW-1:0] exp_q[$];
    logic [PW-1:0] dir_words[$];
    int rem = 0;
    int mod_cur = 256;
    int words_used = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int popped = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int req_lat = -1;
    int hs_cyc = 0;
    int first_lat = -1;
    bit got_hs = 1'b0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        n_chk++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, req);
    endtask

    function automatic logic [PW-1:0] rand_word();
        logic [PW-1:0] w;
        for (int i = 0; i < int'(PW / EW); i++) begin
            if ($urandom_range(0, 3) == 0) w[EW*i +: EW] = 8'hF8 + 8'($urandom_range(0, 7));
            else w[EW*i +: EW] = 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    // Reference: walk the word LSB-first, keep values below the modulus until the job is full.
    function automatic void model_word(input logic [PW-1:0] w);
        for (int i = 0; i < int'(PW / EW); i++) begin
            logic [EW-1:0] c;
            c = w[EW*i +: EW];
            if (rem > 0 && int'(c) < mod_cur) begin
                exp_q.push_back(c);
                rem--;
            end
        end
    endfunction

    // PRNG responder: answers each request with one word after a random delay.
    initial begin : responder
        logic [PW-1:0] w;
        bit hs;
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && preq) begin
                if (dir_words.size() > 0) w = dir_words.pop_front();
                else w = rand_word();
                d = $urandom_range(0, 3);
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1;
                pvalid = 1'b1;
                pword  = w;
                hs = 1'b0;
                for (int i = 0; i < 64 && !hs; i++) begin
                    @(negedge clk);
                    if (pready) hs = 1'b1;
                end
                check("prng_handshake", hs, 1);
                if (hs) begin
                    words_used++;
                    model_word(w);
                end
                @(posedge clk);
                #1;
                pvalid = 1'b0;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: eready = 1'b1;
                1: eready = 1'($urandom_range(0, 1));
                default: eready = 1'b0;
            endcase
        end
    end

    // Monitor: counts pulses, checks hold-under-backpressure and pops the scoreboard.
    initial begin : monitor
        logic pv;
        logic pr;
        logic [EW-1:0] pe;
        pv = 1'b0;
        pr = 1'b0;
        pe = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (preq) begin
                    req_cnt++;
                    check("prng_no_of_bits", nbits, 128);
                    if (req_lat < 0) req_lat = cyc - start_cyc;
                end
                if (done) done_cnt++;
                if (pvalid && pready && !got_hs) begin
                    got_hs = 1'b1;
                    hs_cyc = cyc;
                end
                if (evalid && got_hs && first_lat < 0) first_lat = cyc - hs_cyc;
                if (pv && !pr) begin
                    check("hold_valid", evalid, 1);
                    check("hold_elem", elem, pe);
                end
                if (evalid && eready) begin
                    check("elem_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("elem_value", elem, exp_q.pop_front());
                    popped++;
                end
                pv = evalid;
                pr = eready;
                pe = elem;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_prng_start"}, preq, 0);
        check({tag, "_no_of_bits"}, nbits, 0);
        check({tag, "_prng_ready"}, pready, 0);
        check({tag, "_elem_valid"}, evalid, 0);
        check({tag, "_elem"}, elem, 0);
    endtask

    task automatic begin_job(input bit s, input int n, input int m);
        sel = s;
        mod_cur = m;
        rem = n;
        exp_q.delete();
        req_cnt = 0;
        done_cnt = 0;
        words_used = 0;
        popped = 0;
        got_hs = 1'b0;
        first_lat = -1;
        req_lat = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        nreq = CW'(n);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, n != 0);
    endtask

    task automatic wait_done(input int n, input bit extra);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 200 + 40 * n; i++) begin
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            start = extra && (i % 5 == 1);
            if (start) nreq = CW'($urandom_range(1, 100));
            @(negedge clk);
        end
        check("job_done", fin, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("done_count", done_cnt, 1);
        check("requests_vs_words", req_cnt, words_used);
        check("queue_drained", exp_q.size(), 0);
        check("model_filled", rem, 0);
        check("delivered_count", popped, n);
        if (n == 0) begin
            check("n0_done_latency", done_cyc - start_cyc, 1);
            check("n0_no_prng_start", req_cnt, 0);
        end else begin
            check("start_to_prng_start", req_lat, 1);
        end
    endtask

    initial begin : main
        logic [PW-1:0] w;
        int p0;
        logic [EW-1:0] e0;
        bit seen;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset0");
        sel = 1'b1;
        #1;
        check_outputs_zero("reset1");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Plain bytes across two words, N = 20.
        for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(i);
        dir_words.push_back(w);
        for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16 + i);
        dir_words.push_back(w);
        begin_job(0, 20, 256);
        wait_done(20, 0);
        check("t1_requests", req_cnt, 2);
        check("t1_first_valid_latency", first_lat, 1);

        // Rejections ahead of the first element, MODULUS 251.
        w = rand_word();
        w[47:0] = 48'h01_00_FA_05_FB_FF;
        dir_words.push_back(w);
        begin_job(1, 4, 251);
        wait_done(4, 0);
        check("t2_requests", req_cnt, 1);
        check("t2_first_valid_latency", first_lat, 3);

        // A fully rejected word forces a second request.
        dir_words.push_back({16{8'hFF}});
        dir_words.push_back({{15{8'hFF}}, 8'h2A});
        begin_job(1, 1, 251);
        wait_done(1, 0);
        check("t3_requests", req_cnt, 2);

        // Backpressure: hold ready low for five cycles with an element on offer.
        ready_mode = 2;
        begin_job(0, 8, 256);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = evalid;
        end
        check("t4_valid_seen", seen, 1);
        #2;
        p0 = popped;
        e0 = elem;
        repeat (5) @(negedge clk);
        check("t4_elem_stable", elem, e0);
        check("t4_count_unchanged", popped, p0);
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("t4_next_elem_following_cycle", evalid, 1);
        wait_done(8, 0);

        // N = 0, then a busy job with stray starts.
        begin_job(0, 0, 256);
        wait_done(0, 0);
        begin_job(0, 16, 256);
        wait_done(16, 1);

        // Reset in the middle of unpacking.
        begin_job(0, 16, 256);
        for (int i = 0; i < 200 && popped < 3; i++) begin
            @(negedge clk);
            #2;
        end
        check("t6_reached_three", popped, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        p0 = done_cnt;
        #1;
        check_outputs_zero("t6_rst");
        repeat (3) @(posedge clk);
        exp_q.delete();
        rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_done", done_cnt, p0);
        check("t6_idle_after_reset", busy, 0);
        begin_job(0, 2, 256);
        wait_done(2, 0);

        // Randomised jobs on both moduli with random downstream ready.
        ready_mode = 1;
        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 1) begin
                begin_job(1, n, 251);
            end else begin
                begin_job(0, n, 256);
            end
            wait_done(n, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prng_sample_unpacker.md
Name: prng_sample_unpacker

Overview:
- Consumer and initiator on the aes_ctr_prng output interface.
- Requests 128-bit PRNG words one at a time and splits each word into ELEM_W-bit candidates, LSB first.
- Rejects any candidate >= MODULUS and streams accepted elements downstream on a valid/ready handshake until i_no_of_elems have been delivered.
- Sits between aes_ctr_prng and the field-element consumers (matrix/polynomial expansion).

Parameters:
- PRNG_W, 128, PRNG word width; must be a multiple of ELEM_W.
- ELEM_W, 8, bits per candidate element.
- MODULUS, 256, acceptance bound; candidate accepted iff value < MODULUS; 2**ELEM_W disables rejection.
- CNT_W, 16, width of element count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start pulse; ignored unless idle.
- i_no_of_elems  in  CNT_W  number of accepted elements to deliver; sampled on i_start.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse when the job is complete.
- o_prng_start  out  1  one-cycle request pulse to the PRNG i_start.
- o_prng_no_of_bits  out  16  request length to the PRNG i_no_of_bits; PRNG_W while busy.
- i_prng_out_valid  in  1  PRNG word valid.
- i_prng_out  in  PRNG_W  PRNG word.
- o_prng_out_ready  out  1  high only in WAIT.
- o_elem_valid  out  1  accepted element valid.
- o_elem  out  ELEM_W  accepted element.
- i_elem_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, all outputs 0, including o_prng_no_of_bits and o_elem.
- The PRNG is reset separately by its owner.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, UNPACK, DONE.
- IDLE:
  - i_start with i_no_of_elems != 0 -> REQ; latch target N, clear emitted count, set o_busy.
  - i_start with i_no_of_elems == 0 -> DONE, with no PRNG request.
- REQ: o_prng_start = 1 for exactly one cycle, o_prng_no_of_bits = PRNG_W -> WAIT.
- WAIT:
  - o_prng_out_ready = 1.
  - On i_prng_out_valid && o_prng_out_ready, latch the word into a shift register, slot index = 0 -> UNPACK.
- UNPACK: candidate c = word[ELEM_W*slot +: ELEM_W]; at most one slot is evaluated per cycle.
  - Rejection: c >= MODULUS; advance slot in 1 cycle with no output.
  - Acceptance: drive o_elem = c, o_elem_valid = 1. Hold o_elem and o_elem_valid stable until i_elem_ready. On handshake, increment the emitted count and advance the slot.
  - Back-to-back accepted elements with ready high: one element per cycle.
  - Emitted count reaches N -> DONE immediately; remaining slots of the word are discarded.
  - Last slot (PRNG_W/ELEM_W - 1) consumed and count < N -> REQ.
- DONE: o_done = 1 for one cycle, o_busy drops in the same cycle -> IDLE.
- Latency, i_start (cycle 0) to o_prng_start: high in cycle 1.
- Latency, PRNG handshake (cycle k) to first o_elem_valid: cycle k+1 if slot 0 is accepted.
- i_start while not IDLE: ignored, with no effect on the count or the current word.
- i_prng_out_valid outside WAIT: ignored; o_prng_out_ready is 0, so no word is consumed.
- Comparison is unsigned; when MODULUS = 2**ELEM_W the comparison is constant-true.
- Count comparison is at full CNT_W width; N = 2**CNT_W - 1 is supported.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the partial word is lost; no o_done.

Test Plan:
1. Defaults, N=20:
   - Stimulus: W0 bytes 0x00..0x0F (byte0 = LSB), W1 bytes 0x10..0x1F, ready always high.
   - Required: o_elem 0x00..0x13 in order, exactly 2 o_prng_start pulses each with o_prng_no_of_bits=128, one o_done, W1 bytes 0x14..0x1F discarded.
2. MODULUS=251, N=4:
   - Stimulus: word bytes [0xFF, 0xFB, 0x05, 0xFA, 0x00, 0x01, ...].
   - Required: outputs 0x05, 0xFA, 0x00, 0x01; 1 request; 2 idle UNPACK cycles before the first valid.
3. MODULUS=251, N=1:
   - Stimulus: first word all 0xFF, second word byte0=0x2A.
   - Required: 2 o_prng_start pulses; single output 0x2A; o_done.
4. Backpressure:
   - Stimulus: i_elem_ready held low 5 cycles while o_elem_valid=1.
   - Required: o_elem stable throughout; emitted count unchanged; on release, next element the following cycle.
5. N=0 start, then i_start pulses during a busy N=16 job:
   - Required for N=0: o_done in cycle 1; no o_prng_start.
   - Required for the busy job: extra starts ignored; exactly 16 elements delivered.
6. i_rst_n low mid-UNPACK (after 3 of 16 elements):
   - Required: all outputs 0 in the same cycle; no o_done.
   - After release, a fresh N=2 job delivers 2 elements correctly.
